// File: rtl/mem_arbiter_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mem_arbiter_ctrl_pkg
// Shared types and constants for the multi-port memory controller.
//   mem_width_t    : access width encoding carried on req_width / ram_width
//   mctrl_state_t  : controller FSM states
//   ARB_FIXED/ARB_RR : arbitration mode selectors
//   idx_width()    : width of a port index, never less than 1 bit
// ----------------------------------------------------------------------------
package mem_arbiter_ctrl_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_width_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mctrl_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_ctrl_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter_ctrl_rr_arbiter
// Purely combinational request arbiter.
//   req          in  : one bit per requesting port
//   ptr          in  : round-robin start index (ignored in fixed mode)
//   grant_onehot out : one-hot grant, all zero when nobody requests
//   grant_idx    out : index of the granted port
//   grant_valid  out : at least one port requested
// Fixed mode scans from index 0; round-robin mode scans from ptr and wraps.
// ----------------------------------------------------------------------------
module mem_arbiter_ctrl_rr_arbiter
    import mem_arbiter_ctrl_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int MODE      = ARB_FIXED,
    localparam int IDX_W    = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] grant_onehot,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_valid
);

    int               cand;
    logic [IDX_W-1:0] cidx;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        grant_valid  = 1'b0;
        cand         = 0;
        cidx         = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (MODE == ARB_RR) begin
                cand = (int'(ptr) + i) % NUM_PORTS;
            end else begin
                cand = i;
            end
            cidx = IDX_W'(cand);
            // First requester found in scan order wins.
            if (!grant_valid && req[cidx]) begin
                grant_valid        = 1'b1;
                grant_idx          = cidx;
                grant_onehot[cidx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// ----------------------------------------------------------------------------
// mem_arbiter_ctrl
// Arbitrates NUM_PORTS requesters onto a single RAM port with a ready
// handshake, a one-cycle completion pulse and an ACCESS timeout.
//   CLK, RST            : clock (rising edge), asynchronous active-high reset
//   req_ren/req_wen     : per-port read / write request (write wins)
//   req_addr/req_store  : per-port address / write data, port i at [i*W +: W]
//   req_width           : per-port 2-bit access width
//   req_hit/req_err     : one-cycle completion / timeout pulse per port
//   req_load            : read data, valid while a req_hit bit is high
//   busy                : controller not IDLE
//   ram_*               : RAM request side, driven only in ACCESS
//   ram_load/ram_ready  : RAM read data / completion, sampled in ACCESS
// All outputs are decoded from registered state, so no req_* -> ram_* path.
// ----------------------------------------------------------------------------
module mem_arbiter_ctrl
    import mem_arbiter_ctrl_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ARB_MODE  = ARB_FIXED,
    parameter int TIMEOUT   = 255
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_PORTS-1:0]          req_ren,
    input  logic [NUM_PORTS-1:0]          req_wen,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_store,
    input  logic [NUM_PORTS*2-1:0]        req_width,
    output logic [NUM_PORTS-1:0]          req_hit,
    output logic [NUM_PORTS-1:0]          req_err,
    output logic [DATA_W-1:0]             req_load,
    output logic                          busy,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [DATA_W-1:0]             ram_store,
    output logic [1:0]                    ram_width,
    output logic                          ram_ren,
    output logic                          ram_wen,
    input  logic [DATA_W-1:0]             ram_load,
    input  logic                          ram_ready
);

    localparam int IDX_W = idx_width(NUM_PORTS);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    mctrl_state_t      state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic [1:0]        width_q, width_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] load_q, load_d;

    logic [NUM_PORTS-1:0] req_vec;
    logic [NUM_PORTS-1:0] arb_onehot;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_valid;

    logic [ADDR_W-1:0] addr_arr  [NUM_PORTS];
    logic [DATA_W-1:0] store_arr [NUM_PORTS];
    logic [1:0]        width_arr [NUM_PORTS];

    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] store_sel;
    logic [1:0]        width_sel;
    logic              wen_sel;

    logic in_access;
    logic in_resp;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign req_vec[gi]   = req_ren[gi] | req_wen[gi];
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign store_arr[gi] = req_store[gi*DATA_W +: DATA_W];
            assign width_arr[gi] = req_width[gi*2 +: 2];
            assign req_hit[gi]   = in_resp && (grant_q == IDX_W'(gi));
            assign req_err[gi]   = in_resp && err_q && (grant_q == IDX_W'(gi));
        end
    endgenerate

    mem_arbiter_ctrl_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .MODE      (ARB_MODE)
    ) u_arb (
        .req          (req_vec),
        .ptr          (ptr_q),
        .grant_onehot (arb_onehot),
        .grant_idx    (arb_idx),
        .grant_valid  (arb_valid)
    );

    // AND-OR select of the granted port's request fields.
    always_comb begin
        addr_sel  = '0;
        store_sel = '0;
        width_sel = '0;
        wen_sel   = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (arb_onehot[i]) begin
                addr_sel  = addr_sel  | addr_arr[i];
                store_sel = store_sel | store_arr[i];
                width_sel = width_sel | width_arr[i];
                wen_sel   = wen_sel   | req_wen[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        write_d = write_q;
        addr_d  = addr_q;
        store_d = store_q;
        width_d = width_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        load_d  = load_q;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_idx;
                    write_d = wen_sel;
                    addr_d  = addr_sel;
                    store_d = wen_sel ? store_sel : '0;
                    width_d = width_sel;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    load_d  = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (ram_ready) begin
                    load_d  = write_q ? '0 : ram_load;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Ready still absent after TIMEOUT access cycles.
                    err_d   = 1'b1;
                    load_d  = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (ARB_MODE == ARB_RR) begin
                    ptr_d = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
            width_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            width_q <= width_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            load_q  <= load_d;
        end
    end

    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign ram_ren   = in_access && !write_q;
    assign ram_wen   = in_access && write_q;
    assign ram_addr  = in_access ? addr_q  : '0;
    assign ram_store = in_access ? store_q : '0;
    assign ram_width = in_access ? width_q : '0;
    assign req_load  = in_resp   ? load_q  : '0;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter_ctrl
// Directed bench for mem_arbiter_ctrl. u_fx is a 2-port fixed-priority
// instance, u_rr a 3-port round-robin instance; both use TIMEOUT=4.
// Inputs change 1 time unit after the rising edge, outputs are read there too.
// ----------------------------------------------------------------------------
module tb_mem_arbiter_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int tests_run    = 0;
    int tests_failed = 0;

    // Fixed-priority, 2 ports.
    logic [1:0]  fx_ren, fx_wen, fx_hit, fx_err;
    logic [63:0] fx_addr, fx_store;
    logic [3:0]  fx_width;
    logic [31:0] fx_load, fx_ram_addr, fx_ram_store, fx_ram_load;
    logic [1:0]  fx_ram_width;
    logic        fx_busy, fx_ram_ren, fx_ram_wen, fx_ram_ready;

    // Round-robin, 3 ports.
    logic [2:0]  rr_ren, rr_wen, rr_hit, rr_err;
    logic [95:0] rr_addr, rr_store;
    logic [5:0]  rr_width;
    logic [31:0] rr_load, rr_ram_addr, rr_ram_store, rr_ram_load;
    logic [1:0]  rr_ram_width;
    logic        rr_busy, rr_ram_ren, rr_ram_wen, rr_ram_ready;

    mem_arbiter_ctrl #(
        .NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0), .TIMEOUT(4)
    ) u_fx (
        .CLK(CLK), .RST(RST),
        .req_ren(fx_ren), .req_wen(fx_wen), .req_addr(fx_addr),
        .req_store(fx_store), .req_width(fx_width),
        .req_hit(fx_hit), .req_err(fx_err), .req_load(fx_load), .busy(fx_busy),
        .ram_addr(fx_ram_addr), .ram_store(fx_ram_store), .ram_width(fx_ram_width),
        .ram_ren(fx_ram_ren), .ram_wen(fx_ram_wen),
        .ram_load(fx_ram_load), .ram_ready(fx_ram_ready)
    );

    mem_arbiter_ctrl #(
        .NUM_PORTS(3), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1), .TIMEOUT(4)
    ) u_rr (
        .CLK(CLK), .RST(RST),
        .req_ren(rr_ren), .req_wen(rr_wen), .req_addr(rr_addr),
        .req_store(rr_store), .req_width(rr_width),
        .req_hit(rr_hit), .req_err(rr_err), .req_load(rr_load), .busy(rr_busy),
        .ram_addr(rr_ram_addr), .ram_store(rr_ram_store), .ram_width(rr_ram_width),
        .ram_ren(rr_ram_ren), .ram_wen(rr_ram_wen),
        .ram_load(rr_ram_load), .ram_ready(rr_ram_ready)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        tests_run++; if (fx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_fx_busy: got %0b expected 0", fx_busy); end
        tests_run++; if ({fx_ram_ren, fx_ram_wen} !== 2'b00) begin tests_failed++; $display("FAIL reset_fx_strobes: got %b expected 00", {fx_ram_ren, fx_ram_wen}); end
        tests_run++; if (fx_hit !== 2'b00) begin tests_failed++; $display("FAIL reset_fx_hit: got %b expected 00", fx_hit); end
        tests_run++; if (rr_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_rr_busy: got %0b expected 0", rr_busy); end
        RST = 1'b0;
        tick();
        tests_run++; if (fx_ram_addr !== 32'h0) begin tests_failed++; $display("FAIL idle_fx_addr: got %h expected 0", fx_ram_addr); end
        $display("[TB] reset released");
    endtask

    task automatic test_single_read();
        fx_ren = 2'b10;
        fx_addr[63:32] = 32'h0000_0100;
        fx_width[3:2] = 2'd2;
        tick();
        tests_run++; if (fx_ram_ren !== 1'b1) begin tests_failed++; $display("FAIL rd_ram_ren: got %0b expected 1", fx_ram_ren); end
        tests_run++; if (fx_ram_wen !== 1'b0) begin tests_failed++; $display("FAIL rd_ram_wen: got %0b expected 0", fx_ram_wen); end
        tests_run++; if (fx_ram_addr !== 32'h100) begin tests_failed++; $display("FAIL rd_ram_addr: got %h expected 00000100", fx_ram_addr); end
        tests_run++; if (fx_ram_width !== 2'd2) begin tests_failed++; $display("FAIL rd_ram_width: got %0d expected 2", fx_ram_width); end
        tests_run++; if (fx_hit !== 2'b00) begin tests_failed++; $display("FAIL rd_early_hit: got %b expected 00", fx_hit); end
        fx_ram_ready = 1'b1;
        fx_ram_load = 32'hDEAD_BEEF;
        tick();
        tests_run++; if (fx_hit !== 2'b10) begin tests_failed++; $display("FAIL rd_hit: got %b expected 10", fx_hit); end
        tests_run++; if (fx_load !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL rd_load: got %h expected deadbeef", fx_load); end
        tests_run++; if (fx_ram_ren !== 1'b0) begin tests_failed++; $display("FAIL rd_ren_one_cycle: got %0b expected 0", fx_ram_ren); end
        tests_run++; if (fx_err !== 2'b00) begin tests_failed++; $display("FAIL rd_err: got %b expected 00", fx_err); end
        $display("[TB] read port1 addr 00000100 load %h", fx_load);
        fx_ren = 2'b00;
        fx_ram_ready = 1'b0;
        tick();
        tests_run++; if (fx_busy !== 1'b0) begin tests_failed++; $display("FAIL rd_back_idle: got %0b expected 0", fx_busy); end
    endtask

    task automatic test_write_wait();
        fx_ram_load = 32'hFFFF_FFFF;
        fx_wen = 2'b01;
        fx_addr[31:0] = 32'h0000_0200;
        fx_store[31:0] = 32'h1234_5678;
        fx_width[1:0] = 2'd1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            tests_run++; if ({fx_ram_wen, fx_ram_ren} !== 2'b10) begin tests_failed++; $display("FAIL wr_strobe_c%0d: got %b expected 10", k, {fx_ram_wen, fx_ram_ren}); end
            tests_run++; if (fx_ram_addr !== 32'h200) begin tests_failed++; $display("FAIL wr_addr_c%0d: got %h expected 00000200", k, fx_ram_addr); end
            tests_run++; if (fx_ram_store !== 32'h1234_5678) begin tests_failed++; $display("FAIL wr_store_c%0d: got %h expected 12345678", k, fx_ram_store); end
            tests_run++; if (fx_ram_width !== 2'd1) begin tests_failed++; $display("FAIL wr_width_c%0d: got %0d expected 1", k, fx_ram_width); end
            tests_run++; if (fx_hit !== 2'b00) begin tests_failed++; $display("FAIL wr_early_hit_c%0d: got %b expected 00", k, fx_hit); end
            if (k == 1) begin
                // Changes after the grant must not reach the RAM.
                fx_addr[31:0] = 32'h0000_0999;
                fx_store[31:0] = 32'h0;
            end
            if (k == 3) fx_ram_ready = 1'b1;
        end
        tick();
        tests_run++; if (fx_hit !== 2'b01) begin tests_failed++; $display("FAIL wr_hit: got %b expected 01", fx_hit); end
        tests_run++; if (fx_load !== 32'h0) begin tests_failed++; $display("FAIL wr_load: got %h expected 0", fx_load); end
        tests_run++; if ({fx_ram_wen, fx_ram_width} !== 3'b000) begin tests_failed++; $display("FAIL wr_resp_outputs: got %b expected 000", {fx_ram_wen, fx_ram_width}); end
        $display("[TB] write port0 addr 00000200 store 12345678 done");
        fx_wen = 2'b00;
        fx_ram_ready = 1'b0;
        tick();
    endtask

    task automatic test_fixed_priority();
        fx_ren = 2'b11;
        fx_addr = {32'h0000_0020, 32'h0000_0010};
        fx_ram_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            tests_run++; if (fx_ram_addr !== 32'h10) begin tests_failed++; $display("FAIL fix_addr_t%0d: got %h expected 00000010", t, fx_ram_addr); end
            tick();
            tests_run++; if (fx_hit !== 2'b01) begin tests_failed++; $display("FAIL fix_grant_t%0d: got %b expected 01", t, fx_hit); end
            $display("[TB] fixed txn %0d hit %b", t, fx_hit);
            if (t == 2) fx_ren = 2'b00;
            tick();
        end
        fx_ram_ready = 1'b0;
    endtask

    task automatic test_timeout();
        fx_ren = 2'b01;
        fx_addr[31:0] = 32'h0000_0040;
        fx_ram_load = 32'hA5A5_A5A5;
        fx_ram_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            tests_run++; if ({fx_ram_ren, fx_hit} !== 3'b100) begin tests_failed++; $display("FAIL to_wait_c%0d: got %b expected 100", k, {fx_ram_ren, fx_hit}); end
        end
        tick();
        tests_run++; if (fx_hit !== 2'b01) begin tests_failed++; $display("FAIL to_hit: got %b expected 01", fx_hit); end
        tests_run++; if (fx_err !== 2'b01) begin tests_failed++; $display("FAIL to_err: got %b expected 01", fx_err); end
        tests_run++; if (fx_load !== 32'h0) begin tests_failed++; $display("FAIL to_load: got %h expected 0", fx_load); end
        $display("[TB] timeout port0 hit %b err %b", fx_hit, fx_err);
        fx_ren = 2'b00;
        tick();
        tests_run++; if ({fx_busy, fx_err} !== 3'b000) begin tests_failed++; $display("FAIL to_idle: got %b expected 000", {fx_busy, fx_err}); end
        fx_ren = 2'b10;
        fx_addr[63:32] = 32'h0000_0044;
        tick();
        tests_run++; if (fx_ram_addr !== 32'h44) begin tests_failed++; $display("FAIL to_next_addr: got %h expected 00000044", fx_ram_addr); end
        fx_ram_ready = 1'b1;
        tick();
        tests_run++; if ({fx_hit, fx_err} !== 4'b1000) begin tests_failed++; $display("FAIL to_next_hit: got %b expected 1000", {fx_hit, fx_err}); end
        tests_run++; if (fx_load !== 32'hA5A5_A5A5) begin tests_failed++; $display("FAIL to_next_load: got %h expected a5a5a5a5", fx_load); end
        $display("[TB] read port1 after timeout load %h", fx_load);
        fx_ren = 2'b00;
        fx_ram_ready = 1'b0;
        tick();
    endtask

    // Runs num_txn transactions with the current rr_ren held and checks
    // the granted port against exp_seq.
    task automatic run_rr_seq(input string name, input int num_txn, input int exp_seq[4]);
        logic [2:0]  exp_hit;
        logic [31:0] exp_addr;
        rr_ram_ready = 1'b1;
        for (int t = 0; t < num_txn; t++) begin
            exp_hit  = 3'b001 << exp_seq[t];
            exp_addr = 32'h1000 * (exp_seq[t] + 1);
            tick();
            tests_run++; if (rr_ram_addr !== exp_addr) begin tests_failed++; $display("FAIL %s_addr_t%0d: got %h expected %h", name, t, rr_ram_addr, exp_addr); end
            tick();
            tests_run++; if (rr_hit !== exp_hit) begin tests_failed++; $display("FAIL %s_grant_t%0d: got %b expected %b", name, t, rr_hit, exp_hit); end
            $display("[TB] %s txn %0d hit %b", name, t, rr_hit);
            if (t == num_txn - 1) rr_ren = 3'b000;
            tick();
        end
        rr_ram_ready = 1'b0;
    endtask

    task automatic test_rr_three();
        int exp_seq[4] = '{0, 1, 2, 0};
        rr_addr = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        rr_ren = 3'b111;
        run_rr_seq("rr3", 4, exp_seq);
    endtask

    task automatic test_reset_mid_access();
        // Pointer sits at 1 here, so only port 2 is granted.
        rr_ren = 3'b100;
        rr_ram_ready = 1'b0;
        tick();
        tests_run++; if (rr_ram_addr !== 32'h3000) begin tests_failed++; $display("FAIL rst_pre_addr: got %h expected 00003000", rr_ram_addr); end
        tick();
        RST = 1'b1;
        #1;
        tests_run++; if ({rr_busy, rr_ram_ren, rr_ram_wen} !== 3'b000) begin tests_failed++; $display("FAIL rst_immediate: got %b expected 000", {rr_busy, rr_ram_ren, rr_ram_wen}); end
        tests_run++; if (rr_ram_addr !== 32'h0) begin tests_failed++; $display("FAIL rst_addr: got %h expected 0", rr_ram_addr); end
        rr_ren = 3'b000;
        tick();
        RST = 1'b0;
        tick();
        tests_run++; if ({rr_hit, rr_busy} !== 4'b0000) begin tests_failed++; $display("FAIL rst_no_hit: got %b expected 0000", {rr_hit, rr_busy}); end
        $display("[TB] reset during access, port2 aborted");
    endtask

    task automatic test_rr_alternate();
        int exp_seq[4] = '{0, 1, 0, 1};
        rr_ren = 3'b011;
        run_rr_seq("rr2", 4, exp_seq);
    endtask

    task automatic test_ren_wen();
        rr_ren = 3'b100;
        rr_wen = 3'b100;
        rr_store[95:64] = 32'hCAFE_F00D;
        rr_ram_load = 32'h1111_1111;
        rr_ram_ready = 1'b1;
        tick();
        tests_run++; if ({rr_ram_wen, rr_ram_ren} !== 2'b10) begin tests_failed++; $display("FAIL rw_strobe: got %b expected 10", {rr_ram_wen, rr_ram_ren}); end
        tests_run++; if (rr_ram_store !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL rw_store: got %h expected cafef00d", rr_ram_store); end
        tick();
        tests_run++; if (rr_hit !== 3'b100) begin tests_failed++; $display("FAIL rw_hit: got %b expected 100", rr_hit); end
        tests_run++; if (rr_load !== 32'h0) begin tests_failed++; $display("FAIL rw_load: got %h expected 0", rr_load); end
        $display("[TB] ren+wen port2 performed as write");
        rr_ren = 3'b000;
        rr_wen = 3'b000;
        rr_ram_ready = 1'b0;
        tick();
    endtask

    initial begin
        fx_ren = '0; fx_wen = '0; fx_addr = '0; fx_store = '0; fx_width = '0;
        fx_ram_load = '0; fx_ram_ready = 1'b0;
        rr_ren = '0; rr_wen = '0; rr_addr = '0; rr_store = '0; rr_width = '0;
        rr_ram_load = '0; rr_ram_ready = 1'b0;

        test_reset();
        test_single_read();
        test_write_wait();
        test_fixed_priority();
        test_timeout();
        test_rr_three();
        test_reset_mid_access();
        test_rr_alternate();
        test_ren_wen();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_ctrl.md
# mem_arbiter_ctrl

Parametrised multi-port memory controller between N CPU-side requesters (instruction fetch, data load/store, later DMA/debug) and a single RAM port. Requests are arbitrated in fixed-priority or round-robin order, then driven to RAM over a ready handshake, so any RAM latency is tolerated. Completion is reported with a one-cycle hit pulse, and a stuck RAM is caught by a timeout. It sits between the datapath memory ports and the RAM interface, replacing the single-cycle combinational arbiter.

## Interface
- NUM_PORTS, 2: number of requesters; port 0 = data, port 1 = instruction.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- ARB_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- TIMEOUT, 255: maximum ACCESS cycles before error; must be ≥1.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- req_ren  in  NUM_PORTS  per-port read request.
- req_wen  in  NUM_PORTS  per-port write request; wins over req_ren on the same port.
- req_addr  in  NUM_PORTS*ADDR_W  per-port address; port i is bits [i*ADDR_W +: ADDR_W].
- req_store  in  NUM_PORTS*DATA_W  per-port write data.
- req_width  in  NUM_PORTS*2  per-port mem_width_t.
- req_hit  out  NUM_PORTS  one-cycle completion pulse.
- req_err  out  NUM_PORTS  one-cycle timeout pulse; coincides with req_hit.
- req_load  out  DATA_W  read data; valid only while a req_hit bit is high.
- busy  out  1  high whenever the state is not IDLE.
- ram_addr  out  ADDR_W  RAM address.
- ram_store  out  DATA_W  RAM write data.
- ram_width  out  2  access width.
- ram_ren  out  1  RAM read strobe.
- ram_wen  out  1  RAM write strobe.
- ram_load  in  DATA_W  RAM read data.
- ram_ready  in  1  RAM completion; sampled only in ACCESS.

## Operation
- States are IDLE, ACCESS and RESP.
- **IDLE**
  - If any port has ren|wen, the arbiter picks a grant.
  - Latch grant index, op (write if wen), addr, store and width.
  - Next state is ACCESS; clear the timeout counter.
  - With no request, stay in IDLE with all outputs at 0.
- **ACCESS**
  - Drive ram_* from the latched values; exactly one of ram_ren/ram_wen is high.
  - When ram_ready=1: capture ram_load (reads only, otherwise 0) into the load register and go to RESP.
  - Otherwise increment the counter. When it reaches TIMEOUT-1 with no ready, set the error flag, load 0, and go to RESP.
- **RESP**
  - Assert req_hit[grant] (and req_err[grant] if the error flag is set). req_load = load register.
  - Next state is IDLE.
  - In round-robin mode, the priority pointer moves to grant+1, mod NUM_PORTS.
- **Arbitration**
  - Fixed mode: the lowest set index wins.
  - Round-robin mode: search starts at the pointer and wraps.
- **Requester contract**
  - Hold the request stable until req_hit is seen.
  - Changes after the IDLE latch are ignored.
  - Dropping a request mid-transaction does not abort it; the hit is still issued.
- ram_width and other unused outputs are 0 in IDLE and RESP.
- **Reset**
  - Asynchronous and immediate, including mid-ACCESS.
  - State goes to IDLE; all outputs, latches, counter, error flag and pointer go to 0.
  - No RAM strobe is asserted in the reset cycle.

## Timing
- Cycle 0: request sampled in IDLE.
- Cycle 1: ACCESS with strobes.
- With ready at ACCESS cycle k (k≥1), hit comes in cycle k+1. Minimum request-to-hit is 2 cycles.
- Back-to-back: the next grant is sampled in the IDLE cycle after RESP, so throughput is one transaction per 3 cycles at zero wait.
- Timeout: the hit/err pulse comes exactly TIMEOUT+1 cycles after the IDLE grant.
- ram_ready during IDLE or RESP is ignored.
- Outputs are registered or decoded from registered state only. There is no combinational path from req_* to ram_*.

## Structure
- rv32ima_pkg additions:
  - mem_width_t (BYTE=0, HALF=1, WORD=2)
  - mctrl_state_t (IDLE, ACCESS, RESP)
  - localparams ARB_FIXED=0 and ARB_RR=1
- Sub-module rr_arbiter, parametrised by NUM_PORTS and MODE.
  - Inputs: request vector and pointer.
  - Output: one-hot grant plus index.
  - Purely combinational.

## Test plan
- **Single read, zero wait:** port 1 ren, addr 0x0000_0100, RAM ready in the first ACCESS cycle with ram_load=0xDEADBEEF. Expect req_hit[1] at cycle 2 with req_load=0xDEADBEEF and ram_ren high for exactly 1 cycle.
- **Write with wait states:** port 0 wen, addr 0x200, store 0x12345678, width HALF, ready after 3 cycles. Expect ram_wen held 3 cycles with stable addr/store/width, then hit[0] with req_load=0.
- **Priority:** ports 0 and 1 both request continuously.
  - ARB_MODE=0: grants are 0,0,0…
  - ARB_MODE=1: grants alternate 0,1,0,1.
  - NUM_PORTS=3 with all requesting: grants cycle 0,1,2,0.
- **Timeout:** TIMEOUT=4, ready never asserted. Expect hit[0]=err[0]=1 and req_load=0 exactly 5 cycles after grant; the next request is then served normally.
- **Reset mid-ACCESS:** assert RST during wait cycle 2. Expect all outputs 0 immediately, no hit issued, the round-robin pointer back at 0, and the first post-reset grant to port 0.
- **Same-port ren+wen:** expect the write to be performed and no read issued.
